// File: rtl/bus_gate_pkg.sv
// rtl/bus_gate_pkg.sv - shared state encoding and width helper for bus_gate_mux
package bus_gate_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_gate_scan_ctr.sv
// rtl/bus_gate_scan_ctr.sv - round-robin dwell divider and channel scanner
module bus_gate_scan_ctr
    import bus_gate_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int SCAN_DIV = 8,
    localparam int CW       = clog2(N),
    localparam int DW       = (SCAN_DIV > 1) ? clog2(SCAN_DIV) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_restart,
    input  logic          i_run,
    output logic [CW-1:0] o_ch_nxt
);

    logic [CW-1:0] r_ch;
    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_nxt;
    logic [CW-1:0] w_ch_nxt;
    logic          w_advance;
    logic          w_wrap;

    assign w_advance = i_run && (r_div == DW'(SCAN_DIV - 1));
    assign w_wrap    = w_advance && (r_ch == CW'(N - 1));

    // Expose the next channel so the output stage tracks the scanner on the same edge
    always_comb begin
        w_ch_nxt  = r_ch;
        w_div_nxt = r_div;
        if (i_restart) begin
            w_ch_nxt  = '0;
            w_div_nxt = '0;
        end else if (i_run) begin
            w_div_nxt = w_advance ? '0 : r_div + 1'b1;
            if (w_wrap)         w_ch_nxt = '0;
            else if (w_advance) w_ch_nxt = r_ch + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch  <= '0;
            r_div <= '0;
        end else begin
            r_ch  <= w_ch_nxt;
            r_div <= w_div_nxt;
        end
    end

    assign o_ch_nxt = w_ch_nxt;

endmodule

// File: rtl/bus_gate_mux.sv
// rtl/bus_gate_mux.sv - N-channel register bank gated onto a registered output bus
module bus_gate_mux
    import bus_gate_pkg::*;
#(
    parameter  int           W        = 4,
    parameter  int           N        = 4,
    parameter  int           SCAN_DIV = 8,
    parameter  logic [W-1:0] INIT     = 4'b1100,
    localparam int           CW       = clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel,
    input  logic          mode,
    input  logic [CW-1:0] ch_sel,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_ch,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  out,
    output logic [CW-1:0] out_ch,
    output logic          out_valid,
    output logic          wr_err
);

    localparam logic [CW:0] NMAX = (CW + 1)'(N);

    logic [W-1:0]  r_ch_reg [N];
    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_out;
    logic [CW-1:0] r_out_ch;
    logic          r_out_valid;
    logic          r_wr_err;
    logic [CW-1:0] w_scan_ch;
    logic [CW-1:0] w_cur_ch;
    logic          w_cur_ok;
    logic          w_wr_ok;
    logic          w_scan_restart;
    logic          w_scan_run;

    always_comb begin
        w_state_nxt = IDLE;
        if (sel) w_state_nxt = mode ? SCAN : DIRECT;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Scan position is restarted only on entry; leaving SCAN simply freezes it
    assign w_scan_restart = (w_state_nxt == SCAN) && (r_state != SCAN);
    assign w_scan_run     = (w_state_nxt == SCAN) && (r_state == SCAN);

    bus_gate_scan_ctr #(
        .N        (N),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_ctr (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_scan_restart),
        .i_run     (w_scan_run),
        .o_ch_nxt  (w_scan_ch)
    );

    assign w_cur_ch = (w_state_nxt == SCAN) ? w_scan_ch : ch_sel;
    assign w_cur_ok = ({1'b0, w_cur_ch} < NMAX);
    assign w_wr_ok  = ({1'b0, wr_ch} < NMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_ch_reg[i] <= INIT;
            r_out       <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_wr_err    <= 1'b0;
        end else begin
            r_wr_err <= wr_en && !w_wr_ok;
            if (wr_en && w_wr_ok) r_ch_reg[wr_ch] <= wr_data;

            // Output reads the pre-write bank: a same-edge write shows up one cycle later
            if (w_state_nxt == IDLE) begin
                r_out       <= '0;
                r_out_valid <= 1'b0;
            end else if (!w_cur_ok) begin
                r_out       <= '0;
                r_out_valid <= 1'b0;
                r_out_ch    <= w_cur_ch;
            end else begin
                r_out       <= r_ch_reg[w_cur_ch] & {W{sel}};
                r_out_ch    <= w_cur_ch;
                r_out_valid <= 1'b1;
            end
        end
    end

    assign out       = r_out;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
    assign wr_err    = r_wr_err;

endmodule

// File: tb/tb_bus_gate_mux.sv
// tb/tb_bus_gate_mux.sv - self-checking bench for bus_gate_mux (N=4 and N=3 instances)
module tb_bus_gate_mux;

    logic       clk = 1'b0;
    logic       rst, sel, mode, wr_en;
    logic [1:0] ch_sel, wr_ch;
    logic [3:0] wr_data;

    logic [3:0] out_a, out_b;
    logic [1:0] och_a, och_b;
    logic       ov_a, ov_b, err_a, err_b;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    always #5 clk = ~clk;

    bus_gate_mux #(.W(4), .N(4), .SCAN_DIV(8), .INIT(4'b1100)) u_dut4 (
        .clk(clk), .rst(rst), .sel(sel), .mode(mode), .ch_sel(ch_sel),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .out(out_a), .out_ch(och_a), .out_valid(ov_a), .wr_err(err_a)
    );

    bus_gate_mux #(.W(4), .N(3), .SCAN_DIV(2), .INIT(4'b1100)) u_dut3 (
        .clk(clk), .rst(rst), .sel(sel), .mode(mode), .ch_sel(ch_sel),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .out(out_b), .out_ch(och_b), .out_valid(ov_b), .wr_err(err_b)
    );

    // Reference model: index 0 mirrors u_dut4, index 1 mirrors u_dut3
    int n_ch [2] = '{4, 3};
    int dwell [2] = '{8, 2};
    int regs [2][4];
    int e_out [2], e_ch [2], e_val [2], e_err [2];
    bit in_scan [2];
    int scan_t [2];

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int c = 0; c < 4; c++) regs[k][c] = 12;
                e_out[k] = 0; e_ch[k] = 0; e_val[k] = 0; e_err[k] = 0;
                in_scan[k] = 0;
            end else begin
                e_err[k] = (wr_en && int'(wr_ch) >= n_ch[k]) ? 1 : 0;
                if (!sel) begin
                    e_out[k] = 0; e_val[k] = 0; in_scan[k] = 0;
                end else if (!mode) begin
                    in_scan[k] = 0;
                    e_ch[k] = int'(ch_sel);
                    if (int'(ch_sel) >= n_ch[k]) begin
                        e_out[k] = 0; e_val[k] = 0;
                    end else begin
                        e_out[k] = regs[k][ch_sel]; e_val[k] = 1;
                    end
                end else begin
                    if (!in_scan[k]) begin
                        in_scan[k] = 1; scan_t[k] = 0;
                    end else begin
                        scan_t[k]++;
                    end
                    e_ch[k]  = (scan_t[k] / dwell[k]) % n_ch[k];
                    e_out[k] = regs[k][e_ch[k]];
                    e_val[k] = 1;
                end
                if (wr_en && int'(wr_ch) < n_ch[k]) regs[k][wr_ch] = int'(wr_data);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("u4.out",       int'(out_a), e_out[0]);
                chk("u4.out_ch",    int'(och_a), e_ch[0]);
                chk("u4.out_valid", int'(ov_a),  e_val[0]);
                chk("u4.wr_err",    int'(err_a), e_err[0]);
                chk("u3.out",       int'(out_b), e_out[1]);
                chk("u3.out_ch",    int'(och_b), e_ch[1]);
                chk("u3.out_valid", int'(ov_b),  e_val[1]);
                chk("u3.wr_err",    int'(err_b), e_err[1]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        started = 1;
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input bit s, input bit m, input int cs,
                         input bit we, input int wc, input int wd);
        rst = r; sel = s; mode = m; ch_sel = 2'(cs);
        wr_en = we; wr_ch = 2'(wc); wr_data = 4'(wd);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        cyc(); cyc();
        chk("rst.out", int'(out_a), 0);
        chk("rst.out_ch", int'(och_a), 0);
        chk("rst.valid", int'(ov_a), 0);
        chk("rst.err", int'(err_a), 0);

        drive(0, 1, 0, 2, 0, 0, 0); cyc();
        chk("dir.out", int'(out_a), 12);
        chk("dir.out_ch", int'(och_a), 2);
        chk("dir.valid", int'(ov_a), 1);
        drive(0, 0, 0, 2, 0, 0, 0); cyc();
        chk("gate.out", int'(out_a), 0);
        chk("gate.valid", int'(ov_a), 0);
        chk("gate.out_ch", int'(och_a), 2);

        drive(0, 1, 0, 1, 1, 1, 10); cyc();
        chk("wr.old", int'(out_a), 12);
        drive(0, 1, 0, 1, 0, 0, 0); cyc();
        chk("wr.new", int'(out_a), 10);

        drive(0, 1, 0, 3, 1, 3, 7); cyc();
        chk("n3.out", int'(out_b), 0);
        chk("n3.valid", int'(ov_b), 0);
        chk("n3.out_ch", int'(och_b), 3);
        chk("n3.err", int'(err_b), 1);
        drive(0, 1, 0, 2, 0, 0, 0); cyc();
        chk("n3.err_pulse", int'(err_b), 0);
        chk("n3.ch2_kept", int'(out_b), 12);

        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 0, 1, c, c + 1); cyc();
        end
        drive(0, 1, 1, 0, 0, 0, 0);
        for (int e = 1; e <= 40; e++) begin
            cyc();
            if (e == 1)  chk("scan.e1",  int'(out_a) * 16 + int'(och_a), 1 * 16 + 0);
            if (e == 8)  chk("scan.e8",  int'(och_a), 0);
            if (e == 9)  chk("scan.e9",  int'(out_a) * 16 + int'(och_a), 2 * 16 + 1);
            if (e == 17) chk("scan.e17", int'(out_a) * 16 + int'(och_a), 3 * 16 + 2);
            if (e == 25) chk("scan.e25", int'(out_a) * 16 + int'(och_a), 4 * 16 + 3);
            if (e == 33) chk("scan.e33", int'(out_a) * 16 + int'(och_a), 1 * 16 + 0);
        end

        drive(0, 0, 1, 0, 0, 0, 0); cyc();
        drive(0, 1, 1, 0, 0, 0, 0);
        for (int e = 1; e <= 20; e++) cyc();
        drive(0, 0, 1, 0, 0, 0, 0);
        for (int e = 1; e <= 5; e++) begin
            cyc();
            chk("pause.out", int'(out_a), 0);
            chk("pause.out_ch", int'(och_a), 2);
        end
        drive(0, 1, 1, 0, 0, 0, 0);
        for (int e = 1; e <= 9; e++) begin
            cyc();
            if (e == 1) chk("resume.e1", int'(out_a) * 16 + int'(och_a), 1 * 16 + 0);
            if (e == 8) chk("resume.e8", int'(och_a), 0);
            if (e == 9) chk("resume.e9", int'(och_a), 1);
        end

        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 50) == 0, ($urandom % 4) != 0, $urandom % 2,
                  $urandom % 4, ($urandom % 3) == 0, $urandom % 4, $urandom % 16);
            cyc();
        end

        drive(0, 1, 1, 0, 0, 0, 0);
        for (int e = 0; e < 10; e++) cyc();
        drive(1, 1, 1, 0, 1, 0, 5); cyc();
        chk("rstmid.out", int'(out_a), 0);
        chk("rstmid.valid", int'(ov_a), 0);
        chk("rstmid.out_ch", int'(och_a), 0);
        drive(0, 1, 0, 0, 0, 0, 0); cyc();
        chk("rstmid.ch0", int'(out_a), 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
